clk_lock_monitor: RTL and testbench
===================================

Name: clk_lock_monitor

Overview:
- Receiver-side checker for the divided clocks produced by the clock generator.
- Runs entirely on clk_32f. Samples clk_4f, clk_2f and clk_f as data, measures each half-period, checks phase alignment and reports lock/error status.
- Sits beside the generator and gates downstream datapath enable; also used as a self-check in benches.

Parameters:
- LOCK_COUNT, 4: consecutive correct half-periods required before a channel reports lock.
- CNT_W, 6: half-period counter width; must satisfy 2^CNT_W > 2*HALF_F.

Ports:
- clk_32f  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-low; 0 forces reset state.
- clk_4f  input  1  monitored clock, nominal half-period 4 clk_32f cycles.
- clk_2f  input  1  monitored clock, nominal half-period 8 cycles.
- clk_f  input  1  monitored clock, nominal half-period 16 cycles.
- clr_err  input  1  synchronous clear of err_sticky.
- locked_4f  output  1  clk_4f channel locked.
- locked_2f  output  1  clk_2f channel locked.
- locked_f  output  1  clk_f channel locked.
- locked  output  1  all channels locked and phase-aligned.
- err_4f / err_2f / err_f  output  1 each  one-cycle pulse on a bad half-period or timeout.
- phase_err  output  1  one-cycle pulse on misalignment.
- err_sticky  output  1  set by any error pulse; cleared only by clr_err or reset.

Behaviour:
- Reset (reset==0, asynchronous): all outputs 0, every channel in ACQUIRE, counters 0, sample registers 0.
- Per channel, sampling:
  - s1 <= input; s2 <= s1.
  - edge = s1 ^ s2; rise = s1 & ~s2.
- Per channel, half-period counter: on edge, cnt <= 1; otherwise cnt <= cnt+1, saturating at 2*HALF.
- Per channel, FSM states: ACQUIRE, MEASURE, LOCKED.
  - ACQUIRE: first edge -> MEASURE, good=0. No length check.
  - MEASURE:
    - edge with cnt==HALF: good+1. If good+1==LOCK_COUNT -> LOCKED.
    - edge with cnt!=HALF: err pulse, good=0, stay in MEASURE.
  - LOCKED:
    - edge with cnt==HALF: stay.
    - edge with cnt!=HALF: err pulse -> MEASURE, good=0.
  - Timeout (MEASURE or LOCKED): cnt reaches 2*HALF with no edge -> single err pulse, -> ACQUIRE. No further pulses while stuck.
  - locked_x is 1 exactly in the LOCKED state (registered). It rises on the clk_32f edge that processes the (LOCK_COUNT+1)-th transition seen since ACQUIRE.
- Error precedence: edge and timeout in the same cycle -> edge rules apply.
- Phase check, evaluated only when locked_4f & locked_2f & locked_f:
  - rise_f without rise_2f in the same cycle -> phase_err pulse.
  - rise_2f without rise_4f in the same cycle -> phase_err pulse.
  - Both conditions in one cycle -> a single pulse.
- phase_ok register:
  - cleared by phase_err, or by any channel leaving LOCKED.
  - set on a rise_f with rise_2f & rise_4f while all three channels are locked.
- locked = locked_4f & locked_2f & locked_f & phase_ok.
- err_sticky: set on any err_x or phase_err. Cleared by clr_err only if no error pulse occurs in that cycle; set wins.
- Reset asserted mid-operation: immediate return to reset values. After release, re-acquire from ACQUIRE; no error pulse is produced by the release itself.

Decomposition:
- Shared package: HALF_4F=4, HALF_2F=8, HALF_F=16, state encoding (ACQUIRE=2'd0, MEASURE=2'd1, LOCKED=2'd2).
- One sub-module, clk_period_chk, parameterised by HALF, LOCK_COUNT and CNT_W. Outputs locked, err and rise. Instantiated three times.
- The phase logic and sticky logic live in the top level.

Test Plan:
- Nominal generator output, reset released at t0 -> locked_4f after 5 clk_4f transitions, then locked_2f, then locked_f. locked rises at the first aligned clk_f rise after locked_f. No err or phase_err ever.
- Stretch one clk_2f high phase to 9 cycles after lock -> err_2f pulse once, locked_2f and locked drop, err_sticky=1. Relock after 4 good halves.
- Hold clk_f at 1 after lock -> err_f single pulse exactly 32 cycles after its last edge, channel in ACQUIRE, no repeat pulses.
- Shift clk_2f by one clk_32f cycle (periods correct) -> all channels lock, phase_err pulses at each clk_f rise, locked stays 0.
- Pulse clr_err with no concurrent error -> err_sticky 0 next cycle. Pulse clr_err together with err_4f -> err_sticky stays 1.
- Assert reset mid-lock -> all outputs 0 immediately. On release, re-lock timing is identical to the first scenario.

Source files
------------

// File: rtl/clk_lock_monitor_pkg.sv
// Shared constants and channel state encoding for the divided-clock lock monitor.
// Half-periods are expressed in clk_32f cycles.
package clk_lock_monitor_pkg;

  localparam int HALF_4F = 4;
  localparam int HALF_2F = 8;
  localparam int HALF_F  = 16;

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } chan_state_t;

endpackage

// File: rtl/clk_period_chk.sv
// Half-period checker for one monitored clock sampled as data on clk_32f.
// Reports lock after LOCK_COUNT consecutive correct half-periods, and pulses err on bad lengths or timeout.
module clk_period_chk
  import clk_lock_monitor_pkg::*;
#(
  parameter int HALF       = 4,
  parameter int LOCK_COUNT = 4,
  parameter int CNT_W      = 6
) (
  input  logic clk_32f,
  input  logic reset,
  input  logic clk_in,
  output logic locked,
  output logic err,
  output logic rise
);

  localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0]  HALF_CNT  = CNT_W'(HALF);
  localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(2 * HALF);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_COUNT - 1);

  logic              s1;
  logic              s2;
  logic              toggle;
  logic [CNT_W-1:0]  cnt;
  logic [GOOD_W-1:0] good;
  logic [GOOD_W-1:0] good_next;
  logic              err_next;
  chan_state_t       state;
  chan_state_t       state_next;

  assign toggle = s1 ^ s2;
  assign rise   = s1 & ~s2;
  assign locked = (state == LOCKED);

  // Two-stage sampler; s2 lags s1 so their difference marks a transition.
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= clk_in;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (toggle) begin
      cnt <= CNT_W'(1);
    end else if (cnt != MAX_CNT) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state <= ACQUIRE;
      good  <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_next;
      good  <= good_next;
      err   <= err_next;
    end
  end

  // A transition always takes precedence over a timeout seen in the same cycle.
  always_comb begin
    state_next = state;
    good_next  = good;
    err_next   = 1'b0;
    case (state)
      ACQUIRE: begin
        if (toggle) begin
          state_next = MEASURE;
          good_next  = '0;
        end
      end
      MEASURE: begin
        if (toggle) begin
          if (cnt == HALF_CNT) begin
            if (good == GOOD_LAST) begin
              state_next = LOCKED;
              good_next  = '0;
            end else begin
              good_next = good + GOOD_W'(1);
            end
          end else begin
            err_next  = 1'b1;
            good_next = '0;
          end
        end else if (cnt == MAX_CNT) begin
          err_next   = 1'b1;
          state_next = ACQUIRE;
          good_next  = '0;
        end
      end
      LOCKED: begin
        if (toggle) begin
          if (cnt != HALF_CNT) begin
            err_next   = 1'b1;
            state_next = MEASURE;
            good_next  = '0;
          end
        end else if (cnt == MAX_CNT) begin
          err_next   = 1'b1;
          state_next = ACQUIRE;
          good_next  = '0;
        end
      end
      default: begin
        state_next = ACQUIRE;
        good_next  = '0;
      end
    endcase
  end

endmodule

// File: rtl/clk_lock_monitor.sv
// Lock monitor for the clk_4f/clk_2f/clk_f divided clocks, running on clk_32f.
// Combines per-channel period checks with a rising-edge phase alignment check and sticky error flag.
module clk_lock_monitor
  import clk_lock_monitor_pkg::*;
#(
  parameter int LOCK_COUNT = 4,
  parameter int CNT_W      = 6
) (
  input  logic clk_32f,
  input  logic reset,
  input  logic clk_4f,
  input  logic clk_2f,
  input  logic clk_f,
  input  logic clr_err,
  output logic locked_4f,
  output logic locked_2f,
  output logic locked_f,
  output logic locked,
  output logic err_4f,
  output logic err_2f,
  output logic err_f,
  output logic phase_err,
  output logic err_sticky
);

  logic rise_4f;
  logic rise_2f;
  logic rise_f;
  logic all_locked;
  logic phase_bad;
  logic phase_set;
  logic phase_ok;
  logic any_err;

  clk_period_chk #(.HALF(HALF_4F), .LOCK_COUNT(LOCK_COUNT), .CNT_W(CNT_W)) u_chk_4f (
    .clk_32f (clk_32f),
    .reset   (reset),
    .clk_in  (clk_4f),
    .locked  (locked_4f),
    .err     (err_4f),
    .rise    (rise_4f)
  );

  clk_period_chk #(.HALF(HALF_2F), .LOCK_COUNT(LOCK_COUNT), .CNT_W(CNT_W)) u_chk_2f (
    .clk_32f (clk_32f),
    .reset   (reset),
    .clk_in  (clk_2f),
    .locked  (locked_2f),
    .err     (err_2f),
    .rise    (rise_2f)
  );

  clk_period_chk #(.HALF(HALF_F), .LOCK_COUNT(LOCK_COUNT), .CNT_W(CNT_W)) u_chk_f (
    .clk_32f (clk_32f),
    .reset   (reset),
    .clk_in  (clk_f),
    .locked  (locked_f),
    .err     (err_f),
    .rise    (rise_f)
  );

  // Every slower rising edge must coincide with a rising edge of the next faster clock.
  assign all_locked = locked_4f & locked_2f & locked_f;
  assign phase_bad  = all_locked & ((rise_f & ~rise_2f) | (rise_2f & ~rise_4f));
  assign phase_set  = all_locked & rise_f & rise_2f & rise_4f;
  assign locked     = all_locked & phase_ok;
  assign any_err    = err_4f | err_2f | err_f | phase_err;

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      phase_err <= 1'b0;
      phase_ok  <= 1'b0;
    end else begin
      phase_err <= phase_bad;
      if (!all_locked || phase_bad) begin
        phase_ok <= 1'b0;
      end else if (phase_set) begin
        phase_ok <= 1'b1;
      end
    end
  end

  // A new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      err_sticky <= 1'b0;
    end else if (any_err) begin
      err_sticky <= 1'b1;
    end else if (clr_err) begin
      err_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_clk_lock_monitor.sv
// Directed bench for clk_lock_monitor: a bench-side divider drives the three clocks,
// with per-channel stall/hold controls to create stretched halves, timeouts and phase shifts.
module tb_clk_lock_monitor;

  logic clk_32f = 1'b0;
  logic reset;
  logic clk_4f;
  logic clk_2f;
  logic clk_f;
  logic clr_err;
  logic locked_4f;
  logic locked_2f;
  logic locked_f;
  logic locked;
  logic err_4f;
  logic err_2f;
  logic err_f;
  logic phase_err;
  logic err_sticky;

  int errors = 0;
  int checks = 0;
  int tcount = 0;
  int t0 = 0;
  int n_err4, n_err2, n_errf, n_phase;

  logic [4:0] d4, d2, df;
  logic gen_run, stall_4f, stall_2f, hold_f;
  logic ev_tr_4f, ev_rise_2f, ev_rise_f;

  clk_lock_monitor dut (
    .clk_32f    (clk_32f),
    .reset      (reset),
    .clk_4f     (clk_4f),
    .clk_2f     (clk_2f),
    .clk_f      (clk_f),
    .clr_err    (clr_err),
    .locked_4f  (locked_4f),
    .locked_2f  (locked_2f),
    .locked_f   (locked_f),
    .locked     (locked),
    .err_4f     (err_4f),
    .err_2f     (err_2f),
    .err_f      (err_f),
    .phase_err  (phase_err),
    .err_sticky (err_sticky)
  );

  always #5 clk_32f = ~clk_32f;

  // One clk_32f cycle: sample after the edge, then advance the bench divider.
  task automatic tick();
    logic o4, o2, of;
    @(posedge clk_32f);
    #1;
    tcount++;
    if (err_4f) n_err4++;
    if (err_2f) n_err2++;
    if (err_f) n_errf++;
    if (phase_err) n_phase++;
    o4 = clk_4f;
    o2 = clk_2f;
    of = clk_f;
    if (gen_run) begin
      if (stall_4f) stall_4f = 1'b0; else d4 = d4 - 5'd1;
      if (stall_2f) stall_2f = 1'b0; else d2 = d2 - 5'd1;
      if (!hold_f) df = df - 5'd1;
    end
    clk_4f = d4[2];
    clk_2f = d2[3];
    clk_f  = df[4];
    ev_tr_4f   = clk_4f ^ o4;
    ev_rise_2f = clk_2f & ~o2;
    ev_rise_f  = clk_f & ~of;
  endtask

  task automatic start_gen(input logic shift_2f);
    reset    = 1'b0;
    gen_run  = 1'b0;
    hold_f   = 1'b0;
    stall_4f = 1'b0;
    stall_2f = 1'b0;
    clr_err  = 1'b0;
    d4 = '0;
    d2 = '0;
    df = '0;
    repeat (3) tick();
    reset    = 1'b1;
    t0       = tcount;
    n_err4   = 0;
    n_err2   = 0;
    n_errf   = 0;
    n_phase  = 0;
    stall_2f = shift_2f;
    gen_run  = 1'b1;
  endtask

  task automatic test_reset();
    reset   = 1'b0;
    clr_err = 1'b0;
    clk_4f  = 1'b0;
    clk_2f  = 1'b0;
    clk_f   = 1'b0;
    gen_run = 1'b0;
    d4 = '0;
    d2 = '0;
    df = '0;
    repeat (3) tick();
    checks++;
    if ({locked_4f, locked_2f, locked_f, locked} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_locks: got %b expected 0000", {locked_4f, locked_2f, locked_f, locked});
    end
    checks++;
    if ({err_4f, err_2f, err_f, phase_err, err_sticky} !== 5'b00000) begin
      errors++;
      $display("[TB] FAIL reset_errs: got %b expected 00000", {err_4f, err_2f, err_f, phase_err, err_sticky});
    end
  endtask

  task automatic test_lock_timing(input string name);
    int f4, f2, ff, fl, rel;
    start_gen(1'b0);
    f4 = -1; f2 = -1; ff = -1; fl = -1;
    for (int i = 0; i < 140; i++) begin
      tick();
      rel = tcount - t0;
      if (locked_4f && f4 < 0) f4 = rel;
      if (locked_2f && f2 < 0) f2 = rel;
      if (locked_f && ff < 0) ff = rel;
      if (locked && fl < 0) fl = rel;
    end
    checks++;
    if (f4 !== 19) begin errors++; $display("[TB] FAIL %s_lock_4f: got cycle %0d expected 19", name, f4); end
    checks++;
    if (f2 !== 35) begin errors++; $display("[TB] FAIL %s_lock_2f: got cycle %0d expected 35", name, f2); end
    checks++;
    if (ff !== 67) begin errors++; $display("[TB] FAIL %s_lock_f: got cycle %0d expected 67", name, ff); end
    checks++;
    if (fl !== 99) begin errors++; $display("[TB] FAIL %s_locked: got cycle %0d expected 99", name, fl); end
    checks++;
    if (n_err4 + n_err2 + n_errf + n_phase !== 0) begin
      errors++;
      $display("[TB] FAIL %s_no_errors: got %0d pulses expected 0", name, n_err4 + n_err2 + n_errf + n_phase);
    end
    checks++;
    if (err_sticky !== 1'b0) begin errors++; $display("[TB] FAIL %s_sticky: got %b expected 0", name, err_sticky); end
  endtask

  task automatic test_stretch_2f();
    int r;
    bit found;
    start_gen(1'b0);
    repeat (100) tick();
    found = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ev_rise_2f) begin found = 1; break; end
    end
    checks++;
    if (!found) begin errors++; $display("[TB] FAIL stretch_find_rise: got 0 expected 1"); end
    r = tcount;
    stall_2f = 1'b1;
    n_err2 = 0;
    n_err4 = 0;
    n_errf = 0;
    while (tcount < r + 43) begin
      tick();
      if (tcount == r + 10) begin
        checks++;
        if (err_2f !== 1'b0) begin errors++; $display("[TB] FAIL stretch_err_early: got %b expected 0", err_2f); end
      end
      if (tcount == r + 11) begin
        checks++;
        if ({err_2f, locked_2f, locked} !== 3'b100) begin
          errors++;
          $display("[TB] FAIL stretch_err_drop: got %b expected 100", {err_2f, locked_2f, locked});
        end
      end
      if (tcount == r + 12) begin
        checks++;
        if (err_sticky !== 1'b1) begin errors++; $display("[TB] FAIL stretch_sticky: got %b expected 1", err_sticky); end
      end
      if (tcount == r + 42) begin
        checks++;
        if (locked_2f !== 1'b0) begin errors++; $display("[TB] FAIL stretch_relock_early: got %b expected 0", locked_2f); end
      end
    end
    checks++;
    if (locked_2f !== 1'b1) begin errors++; $display("[TB] FAIL stretch_relock: got %b expected 1", locked_2f); end
    checks++;
    if (n_err2 !== 1 || n_err4 + n_errf !== 0) begin
      errors++;
      $display("[TB] FAIL stretch_pulse_count: got err_2f=%0d others=%0d expected 1 and 0", n_err2, n_err4 + n_errf);
    end
  endtask

  task automatic test_hold_f();
    int r;
    bit found;
    start_gen(1'b0);
    repeat (100) tick();
    found = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ev_rise_f) begin found = 1; break; end
    end
    checks++;
    if (!found) begin errors++; $display("[TB] FAIL hold_find_rise: got 0 expected 1"); end
    r = tcount;
    hold_f = 1'b1;
    n_errf = 0;
    while (tcount < r + 134) begin
      tick();
      if (tcount == r + 33) begin
        checks++;
        if (err_f !== 1'b0) begin errors++; $display("[TB] FAIL hold_err_early: got %b expected 0", err_f); end
      end
      if (tcount == r + 34) begin
        checks++;
        if (err_f !== 1'b1) begin errors++; $display("[TB] FAIL hold_timeout: got %b expected 1", err_f); end
      end
    end
    checks++;
    if (n_errf !== 1) begin errors++; $display("[TB] FAIL hold_single_pulse: got %0d expected 1", n_errf); end
    checks++;
    if ({locked_4f, locked_2f, locked_f, locked} !== 4'b1100) begin
      errors++;
      $display("[TB] FAIL hold_state: got %b expected 1100", {locked_4f, locked_2f, locked_f, locked});
    end
  endtask

  task automatic test_shift_2f();
    int f4, f2, ff, rel, locked_seen, win_phase;
    start_gen(1'b1);
    f4 = -1; f2 = -1; ff = -1;
    locked_seen = 0;
    win_phase = 0;
    for (int i = 0; i < 164; i++) begin
      tick();
      rel = tcount - t0;
      if (locked_4f && f4 < 0) f4 = rel;
      if (locked_2f && f2 < 0) f2 = rel;
      if (locked_f && ff < 0) ff = rel;
      if (locked) locked_seen++;
      if (rel > 100 && phase_err) win_phase++;
    end
    checks++;
    if (f4 !== 19 || f2 !== 36 || ff !== 67) begin
      errors++;
      $display("[TB] FAIL shift_lock_times: got %0d/%0d/%0d expected 19/36/67", f4, f2, ff);
    end
    checks++;
    if (win_phase !== 6) begin errors++; $display("[TB] FAIL shift_phase_pulses: got %0d expected 6", win_phase); end
    checks++;
    if (locked_seen !== 0) begin errors++; $display("[TB] FAIL shift_locked: got %0d cycles expected 0", locked_seen); end
    checks++;
    if (err_sticky !== 1'b1 || n_err4 + n_err2 + n_errf !== 0) begin
      errors++;
      $display("[TB] FAIL shift_errs: got sticky=%b period_errs=%0d expected 1 and 0", err_sticky, n_err4 + n_err2 + n_errf);
    end
  endtask

  task automatic test_clr_err(input bit with_error);
    int s;
    bit found;
    start_gen(1'b0);
    repeat (100) tick();
    found = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ev_tr_4f) begin found = 1; break; end
    end
    checks++;
    if (!found) begin errors++; $display("[TB] FAIL clr_find_edge: got 0 expected 1"); end
    s = tcount;
    stall_4f = 1'b1;
    while (tcount < s + 7) tick();
    checks++;
    if (err_4f !== 1'b1) begin errors++; $display("[TB] FAIL clr_err4f_pulse: got %b expected 1", err_4f); end
    if (with_error) begin
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      checks++;
      if (err_sticky !== 1'b1) begin errors++; $display("[TB] FAIL clr_set_wins: got %b expected 1", err_sticky); end
    end else begin
      tick();
      checks++;
      if (err_sticky !== 1'b1) begin errors++; $display("[TB] FAIL clr_sticky_set: got %b expected 1", err_sticky); end
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      checks++;
      if (err_sticky !== 1'b0) begin errors++; $display("[TB] FAIL clr_clears: got %b expected 0", err_sticky); end
    end
  endtask

  task automatic test_reset_mid_lock();
    start_gen(1'b0);
    repeat (110) tick();
    checks++;
    if (locked !== 1'b1) begin errors++; $display("[TB] FAIL midreset_prelock: got %b expected 1", locked); end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({locked_4f, locked_2f, locked_f, locked, err_4f, err_2f, err_f, phase_err, err_sticky} !== 9'b0) begin
      errors++;
      $display("[TB] FAIL midreset_outputs: got %b expected 000000000",
               {locked_4f, locked_2f, locked_f, locked, err_4f, err_2f, err_f, phase_err, err_sticky});
    end
    test_lock_timing("relock");
  endtask

  initial begin
    $display("[TB] clk_lock_monitor directed bench");
    test_reset();
    test_lock_timing("nominal");
    test_stretch_2f();
    test_hold_f();
    test_shift_2f();
    test_clr_err(1'b0);
    test_clr_err(1'b1);
    test_reset_mid_lock();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
